// File: rtl/logic_arb_pkg.sv
// Types shared by the two-requester logical-unit arbiter.
package logic_arb_pkg;

  // Response slot occupancy
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  // Requester index (two requesters)
  typedef logic [0:0] req_idx_t;

endpackage

// File: rtl/proc_define_pkg.sv
// Shared processor definitions: funct3-coded operation selectors for the
// logical/compare unit. Branch and non-branch codes overlap by design; the
// is_branch qualifier picks the decode table.
package proc_define_pkg;

  // Branch compares (is_branch = 1)
  localparam logic [3:0] BR_BEQ   = 4'b0000;
  localparam logic [3:0] BR_BNE   = 4'b0001;
  localparam logic [3:0] BR_BLT   = 4'b0100;
  localparam logic [3:0] BR_BGE   = 4'b0101;
  localparam logic [3:0] BR_BLTU  = 4'b0110;
  localparam logic [3:0] BR_BGEU  = 4'b0111;

  // Logical / set-less-than ops (is_branch = 0)
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

endpackage

// File: rtl/logic_arbiter_logical.sv
// Logical/compare unit with registered outputs. Results load only when
// en_i is high and hold otherwise, so a stalled consumer sees stable data.
module logical
  import proc_define_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [3:0]  funct_i,
  input  logic        is_branch_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  output logic [31:0] res_o,
  output logic        branch_taken_o
);

  logic [31:0] res_d, res_q;
  logic        taken_d, taken_q;

  // Decode the operation; unsupported codes leave both outputs at zero
  always_comb begin
    res_d   = res_q;
    taken_d = taken_q;
    if (en_i) begin
      res_d   = '0;
      taken_d = 1'b0;
      if (is_branch_i) begin
        case (funct_i)
          BR_BEQ:  taken_d = (op1_i == op2_i);
          BR_BNE:  taken_d = (op1_i != op2_i);
          BR_BLT:  taken_d = ($signed(op1_i) <  $signed(op2_i));
          BR_BGE:  taken_d = ($signed(op1_i) >= $signed(op2_i));
          BR_BLTU: taken_d = (op1_i <  op2_i);
          BR_BGEU: taken_d = (op1_i >= op2_i);
          default: taken_d = 1'b0;
        endcase
      end else begin
        case (funct_i)
          ALU_SLT:  res_d = {31'b0, ($signed(op1_i) < $signed(op2_i))};
          ALU_SLTU: res_d = {31'b0, (op1_i < op2_i)};
          ALU_XOR:  res_d = op1_i ^ op2_i;
          ALU_OR:   res_d = op1_i | op2_i;
          ALU_AND:  res_d = op1_i & op2_i;
          default:  res_d = '0;
        endcase
      end
    end
  end

  // Result registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_q   <= '0;
      taken_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      taken_q <= taken_d;
    end
  end

  assign res_o          = res_q;
  assign branch_taken_o = taken_q;

endmodule

// File: rtl/logic_arbiter.sv
// Round-robin arbiter sharing one logical unit between two requesters.
// One-entry response slot; latency 1, back-to-back at one result/cycle.
module logic_arbiter
  import logic_arb_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [3:0]       req0_funct_i,
  input  logic             req0_is_branch_i,
  input  logic [31:0]      req0_op1_i,
  input  logic [31:0]      req0_op2_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [3:0]       req1_funct_i,
  input  logic             req1_is_branch_i,
  input  logic [31:0]      req1_op1_i,
  input  logic [31:0]      req1_op2_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_src_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic [31:0]      rsp_res_o,
  output logic             rsp_branch_taken_o
);

  arb_state_e       state_d, state_q;
  req_idx_t         last_d, last_q;
  req_idx_t         src_d, src_q;
  logic [TAG_W-1:0] tag_d, tag_q;
  req_idx_t         grant;
  logic             slot_free;
  logic             xfer;
  logic [3:0]       sel_funct;
  logic             sel_is_branch;
  logic [31:0]      sel_op1, sel_op2;

  // Grant selection: sole valid wins; on a tie, the one not granted last.
  // Ready depends only on valids, slot occupancy, rsp_ready_i and reset.
  always_comb begin
    slot_free = (state_q == EMPTY) || rsp_ready_i;
    if (req0_valid_i && req1_valid_i) grant = ~last_q;
    else if (req1_valid_i)            grant = 1'b1;
    else                              grant = 1'b0;
    req0_ready_o = !rst_i && slot_free && req0_valid_i && (grant == 1'b0);
    req1_ready_o = !rst_i && slot_free && req1_valid_i && (grant == 1'b1);
    xfer         = req0_ready_o || req1_ready_o;
  end

  // Operand mux toward the shared unit
  always_comb begin
    sel_funct     = grant[0] ? req1_funct_i     : req0_funct_i;
    sel_is_branch = grant[0] ? req1_is_branch_i : req0_is_branch_i;
    sel_op1       = grant[0] ? req1_op1_i       : req0_op1_i;
    sel_op2       = grant[0] ? req1_op2_i       : req0_op2_i;
  end

  // Slot FSM next state plus pointer/tag/source capture on transfer
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    src_d   = src_q;
    tag_d   = tag_q;
    case (state_q)
      EMPTY:   if (xfer) state_d = FULL;
      FULL:    if (rsp_ready_i && !xfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (xfer) begin
      last_d = grant;
      src_d  = grant;
      tag_d  = grant[0] ? req1_tag_i : req0_tag_i;
    end
  end

  // State registers; reset makes requester 0 win the first tie
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      last_q  <= 1'b1;
      src_q   <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      src_q   <= src_d;
      tag_q   <= tag_d;
    end
  end

  logical u_logical (
    .clk_i          (clk_i),
    .rst_ni         (~rst_i),
    .en_i           (xfer),
    .funct_i        (sel_funct),
    .is_branch_i    (sel_is_branch),
    .op1_i          (sel_op1),
    .op2_i          (sel_op2),
    .res_o          (rsp_res_o),
    .branch_taken_o (rsp_branch_taken_o)
  );

  assign rsp_valid_o = (state_q == FULL);
  assign rsp_src_o   = src_q[0];
  assign rsp_tag_o   = tag_q;

endmodule

// File: tb/tb_logic_arbiter.sv
// Directed bench for logic_arbiter: reset, single issue, round-robin,
// stall hold, compare ops, and reset while a response is held.
module tb_logic_arbiter;

  localparam int TAG_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             req0_valid_i, req0_ready_o, req0_is_branch_i;
  logic [3:0]       req0_funct_i;
  logic [31:0]      req0_op1_i, req0_op2_i;
  logic [TAG_W-1:0] req0_tag_i;
  logic             req1_valid_i, req1_ready_o, req1_is_branch_i;
  logic [3:0]       req1_funct_i;
  logic [31:0]      req1_op1_i, req1_op2_i;
  logic [TAG_W-1:0] req1_tag_i;
  logic             rsp_valid_o, rsp_ready_i, rsp_src_o, rsp_branch_taken_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic [31:0]      rsp_res_o;

  int checks = 0;
  int passed = 0;

  always #5 clk_i = ~clk_i;

  logic_arbiter #(.TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_funct_i(req0_funct_i), .req0_is_branch_i(req0_is_branch_i),
    .req0_op1_i(req0_op1_i), .req0_op2_i(req0_op2_i), .req0_tag_i(req0_tag_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_funct_i(req1_funct_i), .req1_is_branch_i(req1_is_branch_i),
    .req1_op1_i(req1_op1_i), .req1_op2_i(req1_op2_i), .req1_tag_i(req1_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_src_o(rsp_src_o),
    .rsp_tag_o(rsp_tag_o), .rsp_res_o(rsp_res_o),
    .rsp_branch_taken_o(rsp_branch_taken_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set0(input logic v, input logic [3:0] f, input logic br,
                      input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    req0_valid_i = v; req0_funct_i = f; req0_is_branch_i = br;
    req0_op1_i = a; req0_op2_i = b; req0_tag_i = t;
  endtask

  task automatic set1(input logic v, input logic [3:0] f, input logic br,
                      input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    req1_valid_i = v; req1_funct_i = f; req1_is_branch_i = br;
    req1_op1_i = a; req1_op2_i = b; req1_tag_i = t;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    rsp_ready_i = 1'b1;
    set0(1'b1, 4'b0100, 1'b0, 32'h1, 32'h2, 4'h1);
    set1(1'b1, 4'b0100, 1'b0, 32'h3, 32'h4, 4'h2);
    tick();
    tick();
    checks++;
    if (rsp_valid_o !== 1'b0) $display("FAIL reset_valid got %b exp 0", rsp_valid_o); else passed++;
    checks++;
    if ({req0_ready_o, req1_ready_o} !== 2'b00)
      $display("FAIL reset_ready got %b exp 00", {req0_ready_o, req1_ready_o}); else passed++;
    checks++;
    if ({rsp_src_o, rsp_tag_o, rsp_res_o, rsp_branch_taken_o} !== '0)
      $display("FAIL reset_rsp got src=%b tag=%h res=%h bt=%b exp all 0",
               rsp_src_o, rsp_tag_o, rsp_res_o, rsp_branch_taken_o); else passed++;
    set0(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    set1(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_single_xor();
    set0(1'b1, 4'b0100, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'h3);
    #1;
    checks++;
    if (req0_ready_o !== 1'b1) $display("FAIL xor_ready got %b exp 1", req0_ready_o); else passed++;
    tick();
    set0(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    checks++;
    if ({rsp_valid_o, rsp_src_o, rsp_tag_o} !== {1'b1, 1'b0, 4'h3})
      $display("FAIL xor_rsp got v=%b src=%b tag=%h exp v=1 src=0 tag=3",
               rsp_valid_o, rsp_src_o, rsp_tag_o); else passed++;
    checks++;
    if (rsp_res_o !== 32'hFF00_FF00) $display("FAIL xor_res got %h exp ff00ff00", rsp_res_o); else passed++;
    tick();
    checks++;
    if (rsp_valid_o !== 1'b0) $display("FAIL xor_drain got %b exp 0", rsp_valid_o); else passed++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy = 4'b1010;  // bit3 first: grants 0,1,0,1
    do_reset();
    rsp_ready_i = 1'b1;
    set0(1'b1, 4'b0110, 1'b0, 32'h0000_00FF, 32'h0000_FF00, 4'h5);  // OR
    set1(1'b1, 4'b0111, 1'b0, 32'h0000_0FF0, 32'h0000_00FF, 4'h9);  // AND
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({req0_ready_o, req1_ready_o} !== {exp_rdy[3-i], ~exp_rdy[3-i]})
        $display("FAIL rr_ready[%0d] got %b%b exp %b%b", i, req0_ready_o, req1_ready_o,
                 exp_rdy[3-i], ~exp_rdy[3-i]); else passed++;
      tick();
      checks++;
      if (exp_rdy[3-i]) begin
        if ({rsp_valid_o, rsp_src_o, rsp_tag_o, rsp_res_o} !== {1'b1, 1'b0, 4'h5, 32'h0000_FFFF})
          $display("FAIL rr_rsp[%0d] got v=%b src=%b tag=%h res=%h exp 1/0/5/0000ffff",
                   i, rsp_valid_o, rsp_src_o, rsp_tag_o, rsp_res_o); else passed++;
      end else begin
        if ({rsp_valid_o, rsp_src_o, rsp_tag_o, rsp_res_o} !== {1'b1, 1'b1, 4'h9, 32'h0000_00F0})
          $display("FAIL rr_rsp[%0d] got v=%b src=%b tag=%h res=%h exp 1/1/9/000000f0",
                   i, rsp_valid_o, rsp_src_o, rsp_tag_o, rsp_res_o); else passed++;
      end
    end
    set0(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    set1(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
  endtask

  task automatic test_stall();
    rsp_ready_i = 1'b0;
    set1(1'b1, 4'b0100, 1'b1, 32'hFFFF_FFFF, 32'h1, 4'hA);  // BLT
    tick();
    set1(1'b1, 4'b0000, 1'b0, 32'h5, 32'h6, 4'h2);
    set0(1'b1, 4'b0100, 1'b0, 32'h7, 32'h8, 4'h1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rsp_valid_o, rsp_src_o, rsp_tag_o, rsp_branch_taken_o, rsp_res_o} !==
          {1'b1, 1'b1, 4'hA, 1'b1, 32'h0})
        $display("FAIL stall_hold[%0d] got v=%b src=%b tag=%h bt=%b res=%h exp 1/1/a/1/0",
                 i, rsp_valid_o, rsp_src_o, rsp_tag_o, rsp_branch_taken_o, rsp_res_o); else passed++;
      checks++;
      if ({req0_ready_o, req1_ready_o} !== 2'b00)
        $display("FAIL stall_ready[%0d] got %b%b exp 00", i, req0_ready_o, req1_ready_o); else passed++;
      tick();
    end
    rsp_ready_i = 1'b1;
    #1;
    checks++;
    if ({req0_ready_o, req1_ready_o} !== 2'b10)
      $display("FAIL stall_release_ready got %b%b exp 10", req0_ready_o, req1_ready_o); else passed++;
    set0(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    set1(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    checks++;
    if (rsp_valid_o !== 1'b0) $display("FAIL stall_drain got %b exp 0", rsp_valid_o); else passed++;
  endtask

  task automatic test_compare();
    // back-to-back issue from requester 0, one per cycle
    rsp_ready_i = 1'b1;
    set0(1'b1, 4'b0110, 1'b1, 32'hFFFF_FFFF, 32'h1, 4'h1);  // BLTU
    tick();
    checks++;
    if ({rsp_valid_o, rsp_branch_taken_o, rsp_res_o} !== {1'b1, 1'b0, 32'h0})
      $display("FAIL bltu got v=%b bt=%b res=%h exp 1/0/0", rsp_valid_o, rsp_branch_taken_o, rsp_res_o); else passed++;
    set0(1'b1, 4'b0011, 1'b0, 32'hFFFF_FFFF, 32'h1, 4'h2);  // SLTU
    tick();
    checks++;
    if ({rsp_valid_o, rsp_tag_o, rsp_branch_taken_o, rsp_res_o} !== {1'b1, 4'h2, 1'b0, 32'h0})
      $display("FAIL sltu got v=%b tag=%h bt=%b res=%h exp 1/2/0/0",
               rsp_valid_o, rsp_tag_o, rsp_branch_taken_o, rsp_res_o); else passed++;
    set0(1'b1, 4'b0010, 1'b0, 32'hFFFF_FFFF, 32'h1, 4'h3);  // SLT
    tick();
    checks++;
    if ({rsp_valid_o, rsp_tag_o, rsp_branch_taken_o, rsp_res_o} !== {1'b1, 4'h3, 1'b0, 32'h1})
      $display("FAIL slt got v=%b tag=%h bt=%b res=%h exp 1/3/0/1",
               rsp_valid_o, rsp_tag_o, rsp_branch_taken_o, rsp_res_o); else passed++;
    set0(1'b1, 4'b0000, 1'b1, 32'h1234_5678, 32'h1234_5678, 4'h4);  // BEQ
    tick();
    checks++;
    if ({rsp_branch_taken_o, rsp_res_o} !== {1'b1, 32'h0})
      $display("FAIL beq got bt=%b res=%h exp 1/0", rsp_branch_taken_o, rsp_res_o); else passed++;
    set0(1'b1, 4'b0001, 1'b0, 32'hFFFF_0000, 32'h0000_FFFF, 4'h5);  // unsupported non-branch
    tick();
    checks++;
    if ({rsp_tag_o, rsp_branch_taken_o, rsp_res_o} !== {4'h5, 1'b0, 32'h0})
      $display("FAIL unsup_alu got tag=%h bt=%b res=%h exp 5/0/0",
               rsp_tag_o, rsp_branch_taken_o, rsp_res_o); else passed++;
    set0(1'b1, 4'b0010, 1'b1, 32'h0, 32'h1, 4'h6);  // unsupported branch
    tick();
    checks++;
    if ({rsp_tag_o, rsp_branch_taken_o, rsp_res_o} !== {4'h6, 1'b0, 32'h0})
      $display("FAIL unsup_br got tag=%h bt=%b res=%h exp 6/0/0",
               rsp_tag_o, rsp_branch_taken_o, rsp_res_o); else passed++;
    set0(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
  endtask

  task automatic test_reset_mid();
    // leave last-granted = 0 so only reset can restore requester 0's tie win
    rsp_ready_i = 1'b0;
    set0(1'b1, 4'b0100, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 4'h7);
    tick();
    set0(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    checks++;
    if ({rsp_valid_o, rsp_res_o} !== {1'b1, 32'hFFFF_FFFF})
      $display("FAIL mid_held got v=%b res=%h exp 1/ffffffff", rsp_valid_o, rsp_res_o); else passed++;
    rsp_ready_i = 1'b1;
    set0(1'b1, 4'b0111, 1'b0, 32'hFFFF_FFFF, 32'h0000_00F0, 4'h8);
    set1(1'b1, 4'b0110, 1'b0, 32'h0, 32'h0000_000F, 4'hB);
    rst_i = 1'b1;
    #1;
    checks++;
    if ({rsp_valid_o, req0_ready_o, req1_ready_o, rsp_res_o} !== {3'b000, 32'h0})
      $display("FAIL mid_reset got v=%b rdy=%b%b res=%h exp 0/00/0",
               rsp_valid_o, req0_ready_o, req1_ready_o, rsp_res_o); else passed++;
    tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if ({req0_ready_o, req1_ready_o} !== 2'b10)
      $display("FAIL mid_tie got %b%b exp 10", req0_ready_o, req1_ready_o); else passed++;
    tick();
    checks++;
    if ({rsp_valid_o, rsp_src_o, rsp_tag_o, rsp_res_o} !== {1'b1, 1'b0, 4'h8, 32'h0000_00F0})
      $display("FAIL mid_first got v=%b src=%b tag=%h res=%h exp 1/0/8/000000f0",
               rsp_valid_o, rsp_src_o, rsp_tag_o, rsp_res_o); else passed++;
    set0(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    set1(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
  endtask

  initial begin
    test_reset();
    test_single_xor();
    test_round_robin();
    test_stall();
    test_compare();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
